// File: rtl/mddr_io_pkg.sv
// mddr_io_pkg: shared state, pad config type and reset config for the mDDR I/O bank.
package mddr_io_pkg;
  typedef enum logic [2:0] {IDLE, PRE, DRIVE, POST, TURN, PWDN, WAKE} state_t;
  typedef struct packed {
    logic       ds;
    logic [1:0] s;
    logic       lvcmos;
  } cfg_t;
  localparam cfg_t CFG_RESET = '{ds: 1'b0, s: 2'b00, lvcmos: 1'b1};
  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/mddr_io_sync.sv
// mddr_io_sync: parametrised-width two-flop synchroniser.
module mddr_io_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '0;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/mddr_io_bank_ctrl.sv
// mddr_io_bank_ctrl: output-enable, power-down, config and receive sequencing for a bank of mDDR pads.
module mddr_io_bank_ctrl
  import mddr_io_pkg::*;
#(
  parameter int                   NUM_LANES   = 8,
  parameter int                   DIFF        = 0,
  parameter int                   PRE_CYCLES  = 1,
  parameter logic [NUM_LANES-1:0] PRE_PATTERN = '0,
  parameter int                   POST_CYCLES = 1,
  parameter int                   TURN_CYCLES = 2,
  parameter int                   WAKE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [NUM_LANES-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 rx_en,
  output logic [NUM_LANES-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 pwd_req,
  output logic                 pwd_ack,
  input  logic                 cfg_wr,
  input  logic                 cfg_ds,
  input  logic                 cfg_lvcmos,
  input  logic [1:0]           cfg_s,
  output logic                 cfg_pending,
  output logic                 pad_ds,
  output logic                 pad_lvcmos,
  output logic [1:0]           pad_s,
  output logic [NUM_LANES-1:0] pad_i,
  output logic [NUM_LANES-1:0] pad_i_n,
  output logic [NUM_LANES-1:0] pad_oen,
  output logic                 pad_pwd,
  input  logic [NUM_LANES-1:0] pad_c
);
  localparam int CW = $clog2(max4(PRE_CYCLES, POST_CYCLES, TURN_CYCLES, WAKE_CYCLES) + 1);
  state_t               state, ns;
  logic [CW-1:0]        cnt, cnt_d;
  logic [1:0]           run, run_d;
  logic [NUM_LANES-1:0] pad_i_d;
  logic                 accept, drive_d, apply;
  cfg_t                 cfg_q, shadow, cfg_in;
  assign accept = tx_valid && tx_ready;
  assign apply  = state == IDLE || state == PWDN;
  assign cfg_in = '{ds: cfg_ds, s: cfg_s, lvcmos: cfg_lvcmos};
  assign {pad_ds, pad_s, pad_lvcmos} = cfg_q;
  always_comb begin
    ns = state;
    case (state)
      IDLE:    ns = pwd_req ? PWDN : tx_valid ? PRE : IDLE;
      PRE:     ns = cnt == '0 ? DRIVE : PRE;
      DRIVE:   ns = tx_valid ? DRIVE : POST;
      POST:    ns = tx_valid ? DRIVE : cnt == '0 ? TURN : POST;
      TURN:    ns = cnt == '0 ? IDLE : TURN;
      PWDN:    ns = pwd_req ? PWDN : WAKE;
      WAKE:    ns = cnt == '0 ? IDLE : WAKE;
      default: ns = IDLE;
    endcase
    cnt_d = ns != state ? (ns == PRE  ? CW'(PRE_CYCLES - 1)  :
                           ns == POST ? CW'(POST_CYCLES - 1) :
                           ns == TURN ? CW'(TURN_CYCLES - 1) :
                           ns == WAKE ? CW'(WAKE_CYCLES - 1) : '0)
                        : cnt == '0 ? cnt : cnt - 1'b1;
    // run counts consecutive IDLE cycles so rx_valid waits for the synchroniser to refill
    run_d   = ns != IDLE ? 2'd0 : state != IDLE ? 2'd1 : run == 2'd3 ? run : run + 2'd1;
    drive_d = ns == PRE || ns == DRIVE || ns == POST;
    pad_i_d = accept ? tx_data : ns == PRE ? PRE_PATTERN : pad_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      run      <= '0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      pwd_ack  <= 1'b0;
      pad_pwd  <= 1'b0;
      pad_oen  <= '1;
      pad_i    <= '0;
      pad_i_n  <= {NUM_LANES{DIFF != 0}};
    end else begin
      state    <= ns;
      cnt      <= cnt_d;
      run      <= run_d;
      // ready in the last preamble cycle so the first beat lands right after the preamble
      tx_ready <= ns == DRIVE || (ns == PRE && cnt_d == '0);
      rx_valid <= rx_en && run_d == 2'd3;
      pwd_ack  <= ns == PWDN;
      pad_pwd  <= ns == PWDN;
      pad_oen  <= {NUM_LANES{!drive_d}};
      pad_i    <= pad_i_d;
      pad_i_n  <= DIFF != 0 ? ~pad_i_d : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_q       <= CFG_RESET;
      shadow      <= CFG_RESET;
      cfg_pending <= 1'b0;
    end else if (cfg_wr) begin
      shadow      <= cfg_in;
      cfg_q       <= apply ? cfg_in : cfg_q;
      cfg_pending <= !apply;
    end else if (cfg_pending && apply) begin
      cfg_q       <= shadow;
      cfg_pending <= 1'b0;
    end
  mddr_io_sync #(.W(NUM_LANES)) u_sync (.clk(clk), .rst_n(rst_n), .d(pad_c), .q(rx_data));
endmodule

// File: tb/tb_mddr_io_bank_ctrl.sv
// tb_mddr_io_bank_ctrl: directed scoreboard bench for the mDDR I/O bank sequencer.
module tb_mddr_io_bank_ctrl;
  import mddr_io_pkg::*;
  logic clk = 0, rst_n = 0, tx_valid = 0, rx_en = 0, pwd_req = 0, cfg_wr = 0, cfg_ds = 0, cfg_lvcmos = 0;
  logic [7:0] tx_data = 0, pad_c = 0;
  logic [1:0] cfg_s = 0;
  logic tx_ready, rx_valid, pwd_ack, cfg_pending, pad_ds, pad_lvcmos, pad_pwd;
  logic [1:0] pad_s;
  logic [7:0] rx_data, pad_i, pad_i_n, pad_oen;
  logic tx_ready1, rx_valid1, pwd_ack1, cfg_pending1, pad_ds1, pad_lvcmos1, pad_pwd1;
  logic [1:0] pad_s1;
  logic [7:0] rx_data1, pad_i1, pad_i_n1, pad_oen1;
  int cyc = 0, vectors = 0, errors = 0;
  typedef struct {int at; int sel; logic [7:0] val; string name;} exp_t;
  exp_t sb[$];

  mddr_io_bank_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid), .pwd_req(pwd_req), .pwd_ack(pwd_ack),
    .cfg_wr(cfg_wr), .cfg_ds(cfg_ds), .cfg_lvcmos(cfg_lvcmos), .cfg_s(cfg_s), .cfg_pending(cfg_pending),
    .pad_ds(pad_ds), .pad_lvcmos(pad_lvcmos), .pad_s(pad_s), .pad_i(pad_i), .pad_i_n(pad_i_n),
    .pad_oen(pad_oen), .pad_pwd(pad_pwd), .pad_c(pad_c));

  mddr_io_bank_ctrl #(.DIFF(1)) dut_diff (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready1),
    .rx_en(rx_en), .rx_data(rx_data1), .rx_valid(rx_valid1), .pwd_req(pwd_req), .pwd_ack(pwd_ack1),
    .cfg_wr(cfg_wr), .cfg_ds(cfg_ds), .cfg_lvcmos(cfg_lvcmos), .cfg_s(cfg_s), .cfg_pending(cfg_pending1),
    .pad_ds(pad_ds1), .pad_lvcmos(pad_lvcmos1), .pad_s(pad_s1), .pad_i(pad_i1), .pad_i_n(pad_i_n1),
    .pad_oen(pad_oen1), .pad_pwd(pad_pwd1), .pad_c(pad_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] probe(int sel);
    case (sel)
      0:       return pad_oen;
      1:       return pad_i;
      2:       return {7'd0, tx_ready};
      3:       return {7'd0, rx_valid};
      4:       return {7'd0, pwd_ack};
      5:       return {7'd0, pad_pwd};
      6:       return {7'd0, cfg_pending};
      7:       return {4'd0, pad_ds, pad_s, pad_lvcmos};
      8:       return rx_data;
      9:       return {5'd0, dut.state};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(string n, logic [7:0] got, logic [7:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, want, cyc);
    end
  endtask

  task automatic ex(int at, int sel, logic [7:0] v, string n);
    sb.push_back('{at, sel, v, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: retire every scoreboard entry due this cycle, plus per-cycle pad_i_n invariants
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        chk(sb[i].name, probe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    chk("diff_pad_i_n", pad_i_n1, ~pad_i1);
    chk("single_pad_i_n", pad_i_n, 8'h00);
  end

  initial begin
    int t, u, p, q;
    ex(1, 0, 8'hFF, "rst_oen");     ex(1, 1, 8'h00, "rst_pad_i");   ex(1, 2, 8'h00, "rst_tx_ready");
    ex(1, 3, 8'h00, "rst_rx_valid"); ex(1, 4, 8'h00, "rst_pwd_ack"); ex(1, 5, 8'h00, "rst_pad_pwd");
    ex(1, 6, 8'h00, "rst_pending");  ex(1, 7, 8'h01, "rst_cfg");     ex(1, 8, 8'h00, "rst_rx_data");
    repeat (3) tick();
    rst_n = 1;
    repeat (4) tick();
    // burst A5,3C,FF with a config write during DRIVE and receive enabled throughout
    tx_valid = 1; tx_data = 8'hA5; rx_en = 1; pad_c = 8'h5A; t = cyc + 1;
    ex(t, 0, 8'h00, "pre_oen"); ex(t, 1, 8'h00, "pre_pattern"); ex(t, 2, 8'h01, "pre_ready");
    ex(t+1, 1, 8'hA5, "beat0"); ex(t+2, 1, 8'h3C, "beat1"); ex(t+3, 1, 8'hFF, "beat2");
    ex(t+4, 1, 8'hFF, "post_hold"); ex(t+4, 0, 8'h00, "post_oen"); ex(t+4, 2, 8'h00, "post_ready");
    ex(t+5, 0, 8'hFF, "turn_oen0"); ex(t+6, 0, 8'hFF, "turn_oen1"); ex(t+6, 9, 8'(TURN), "turn_state");
    ex(t+7, 9, 8'(IDLE), "burst_idle");
    ex(t+2, 3, 8'h00, "rx_busy"); ex(t+8, 3, 8'h00, "rx_refill"); ex(t+9, 3, 8'h01, "rx_valid");
    ex(t+9, 8, 8'h5A, "rx_data");
    ex(t+2, 6, 8'h01, "cfg_pend"); ex(t+7, 7, 8'h01, "cfg_held"); ex(t+7, 6, 8'h01, "cfg_pend_idle");
    ex(t+8, 7, 8'h0F, "cfg_applied"); ex(t+8, 6, 8'h00, "cfg_cleared");
    tick();
    tick(); tx_data = 8'h3C; cfg_wr = 1; cfg_ds = 1; cfg_s = 2'b11; cfg_lvcmos = 1;
    tick(); tx_data = 8'hFF; cfg_wr = 0;
    tick(); tx_valid = 0;
    repeat (6) tick();
    pad_c = 8'hC3;
    ex(t+10, 8, 8'h5A, "rx_old"); ex(t+11, 8, 8'hC3, "rx_resync"); ex(t+11, 3, 8'h01, "rx_valid_hold");
    repeat (3) tick();
    rx_en = 0;
    // gap: one idle cycle lands in POST, DRIVE resumes without a new preamble
    repeat (2) tick();
    tx_valid = 1; tx_data = 8'hA5; u = cyc + 1;
    for (int k = 0; k < 6; k++) ex(u+k, 0, 8'h00, "gap_oen");
    ex(u+1, 9, 8'(DRIVE), "gap_drive"); ex(u+2, 9, 8'(POST), "gap_post"); ex(u+3, 9, 8'(DRIVE), "gap_resume");
    ex(u+2, 2, 8'h00, "gap_post_ready"); ex(u+3, 2, 8'h01, "gap_ready"); ex(u+3, 1, 8'hA5, "gap_no_pre");
    ex(u+4, 1, 8'h3C, "gap_beat"); ex(u+6, 0, 8'hFF, "gap_turn"); ex(u+8, 9, 8'(IDLE), "gap_idle");
    tick();
    tick(); tx_valid = 0;
    tick(); tx_valid = 1; tx_data = 8'h3C;
    tick();
    tick(); tx_valid = 0;
    repeat (5) tick();
    // power-down requested mid-burst, config applied directly in PWDN, re-request in WAKE ignored
    tick();
    tx_valid = 1; tx_data = 8'hA5; p = cyc + 1;
    ex(p+1, 1, 8'hA5, "pwd_beat"); ex(p+2, 0, 8'h00, "pwd_burst_post"); ex(p+5, 9, 8'(IDLE), "pwd_idle");
    ex(p+5, 4, 8'h00, "pwd_ack_wait"); ex(p+6, 4, 8'h01, "pwd_ack"); ex(p+6, 5, 8'h01, "pad_pwd");
    ex(p+6, 0, 8'hFF, "pwd_oen"); ex(p+7, 7, 8'h02, "cfg_pwdn"); ex(p+7, 6, 8'h00, "cfg_pwdn_pend");
    ex(p+8, 5, 8'h00, "wake_pad_pwd"); ex(p+8, 4, 8'h00, "wake_ack"); ex(p+8, 9, 8'(WAKE), "wake_state");
    ex(p+23, 9, 8'(WAKE), "wake_last"); ex(p+24, 9, 8'(IDLE), "wake_idle"); ex(p+25, 9, 8'(PWDN), "repwd");
    ex(p+26, 9, 8'(WAKE), "rewake"); ex(p+42, 9, 8'(IDLE), "rewake_idle");
    tick(); pwd_req = 1;
    tick(); tx_valid = 0;
    repeat (5) tick();
    cfg_wr = 1; cfg_ds = 0; cfg_s = 2'b01; cfg_lvcmos = 0;
    tick(); cfg_wr = 0; pwd_req = 0;
    repeat (3) tick(); pwd_req = 1;
    repeat (15) tick(); pwd_req = 0;
    repeat (18) tick();
    // config write in IDLE applies on the next cycle with no pending phase
    cfg_wr = 1; cfg_ds = 1; cfg_s = 2'b01; cfg_lvcmos = 0; q = cyc + 1;
    ex(q, 7, 8'h0A, "cfg_idle"); ex(q, 6, 8'h00, "cfg_idle_pend");
    tick(); cfg_wr = 0;
    tick();
    // asynchronous reset mid-DRIVE
    tx_valid = 1; tx_data = 8'h3C;
    tick(); tick();
    chk("pre_rst_oen", pad_oen, 8'h00);
    chk("pre_rst_pad_i", pad_i, 8'h3C);
    #2 rst_n = 0;
    #1;
    chk("arst_oen", pad_oen, 8'hFF);
    chk("arst_pad_i", pad_i, 8'h00);
    chk("arst_diff_n", pad_i_n1, 8'hFF);
    chk("arst_ready", {7'd0, tx_ready}, 8'h00);
    chk("arst_cfg", {4'd0, pad_ds, pad_s, pad_lvcmos}, 8'h01);
    chk("arst_state", {5'd0, dut.state}, 8'(IDLE));
    tx_valid = 0;
    tick(); rst_n = 1;
    repeat (3) tick();
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: got %0d unchecked entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
